// File: rtl/img_pkg.sv
// Shared image constants and readback FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package img_pkg;

    // Frame geometry defaults. The copy controller uses the same values.
    localparam int IMG_WIDTH  = 800;
    localparam int IMG_HEIGHT = 600;
    localparam int IMG_SIZE   = IMG_WIDTH * IMG_HEIGHT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous first-word-fall-through FIFO for pixels (DATA_W x DEPTH).
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: pop is ignored when empty; push is dropped when full and not popping.
// Ports: clk/rst, push + push_data in, pop in, head/head_vld/occ out.
module pix_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       head_vld,
    output logic [$clog2(DEPTH):0]     occ
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_q;
    logic              pop_q;

    assign head_vld = (occ != '0);
    assign head     = mem[rd_ptr];
    assign pop_q    = pop && head_vld;
    assign push_q   = push && ((occ != FULL_OCC) || pop_q);

    // Storage needs no reset: occ gates every read of it.
    always_ff @(posedge clk) begin
        if (push_q) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_q) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_q, pop_q})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/out_mem_reader.sv
// Reads the whole output image out of out_mem in raster order and streams it as pixels.
// Latency: start sampled high -> first read next cycle -> pix_valid 3 cycles after start.
// Backpressure: reads are throttled so FIFO + in-flight never exceed FIFO_DEPTH; no data lost.
// Ports: clk/rst, start, out_mem read port (en/read/write/addr/rdata),
//        pixel stream (valid/ready/data + sol/eol/sof/eof), busy/done status.
module out_mem_reader
    import img_pkg::*;
#(
    parameter int WIDTH      = IMG_WIDTH,
    parameter int HEIGHT     = IMG_HEIGHT,
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              en_out_mem,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [ADDR_W-1:0] out_mem_addr,
    input  logic [DATA_W-1:0] out_mem_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              pix_sof,
    output logic              pix_eof,
    output logic              busy,
    output logic              done
);

    localparam int SIZE  = WIDTH * HEIGHT;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);
    localparam logic [31:0]       COL_LAST  = 32'(WIDTH - 1);
    localparam logic [31:0]       ROW_LAST  = 32'(HEIGHT - 1);
    localparam logic [31:0]       DEPTH_L   = FIFO_DEPTH;

    rd_state_t         state;
    logic [ADDR_W-1:0] next_addr;
    logic              inflight;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_vld;
    logic [OCC_W-1:0]  occ;
    logic              pop;
    logic [31:0]       pending;
    logic              can_issue;
    logic              drain_empty;
    logic [31:0]       col;
    logic [31:0]       row;

    assign out_mem_read  = en_out_mem;
    assign out_mem_write = 1'b0;

    assign pop = fifo_vld && pix_ready;

    // Slots that will be committed after this edge: what sits in the FIFO, the read
    // returning now, and the read being issued now, minus the pixel leaving now.
    // A new read is only issued if that leaves room for it.
    assign pending   = 32'(occ) + 32'(inflight) + 32'(en_out_mem) - 32'(pop);
    assign can_issue = (pending < DEPTH_L);

    // Nothing outstanding and the last pixel is either gone or leaving this cycle.
    assign drain_empty = !inflight && !en_out_mem &&
                         ((occ == '0) || ((occ == OCC_W'(1)) && pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            en_out_mem   <= 1'b0;
            out_mem_addr <= '0;
            next_addr    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    en_out_mem <= 1'b0;
                    // FIFO is empty here, so address 0 can be issued immediately.
                    if (start) begin
                        state        <= (SIZE == 1) ? S_DRAIN : S_READ;
                        en_out_mem   <= 1'b1;
                        out_mem_addr <= '0;
                        next_addr    <= ADDR_W'(1);
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                S_READ: begin
                    if (can_issue) begin
                        en_out_mem   <= 1'b1;
                        out_mem_addr <= next_addr;
                        next_addr    <= next_addr + ADDR_W'(1);
                        if (next_addr == LAST_ADDR) begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        en_out_mem <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    en_out_mem <= 1'b0;
                    if (drain_empty) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    en_out_mem <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    // Read data is valid one cycle after the enable; clearing this on reset is what
    // discards data still returning from a read issued before the reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= en_out_mem;
        end
    end

    pix_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (out_mem_rdata),
        .pop       (pop),
        .head      (fifo_head),
        .head_vld  (fifo_vld),
        .occ       (occ)
    );

    // Position of the head pixel; advances only on an accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 32'd1;
            end else begin
                col <= col + 32'd1;
            end
        end
    end

    // Everything on the stream is forced to 0 while no pixel is at the head.
    assign pix_valid = fifo_vld;
    assign pix_data  = fifo_vld ? fifo_head : '0;
    assign pix_sol   = fifo_vld && (col == '0);
    assign pix_eol   = fifo_vld && (col == COL_LAST);
    assign pix_sof   = fifo_vld && (col == '0) && (row == '0);
    assign pix_eof   = fifo_vld && (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: tb/tb_out_mem_reader.sv
module tb_out_mem_reader;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk;
    logic        rst;
    logic        start;
    logic        en_out_mem;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [31:0] out_mem_addr;
    logic [23:0] out_mem_rdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_sol;
    logic        pix_eol;
    logic        pix_sof;
    logic        pix_eof;
    logic        busy;
    logic        done;

    logic [3:0]  marks;
    assign marks = {pix_sof, pix_eof, pix_sol, pix_eol};

    int vecs = 0;
    int errs = 0;

    logic [23:0] q_data [$];
    logic [3:0]  q_mark [$];
    int stab_viol;
    int over_viol;
    int addr_viol;
    int wr_viol;

    out_mem_reader #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DATA_W     (24),
        .ADDR_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .en_out_mem    (en_out_mem),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_mem_addr  (out_mem_addr),
        .out_mem_rdata (out_mem_rdata),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_sol       (pix_sol),
        .pix_eol       (pix_eol),
        .pix_sof       (pix_sof),
        .pix_eof       (pix_eof),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: mem[a] = a + 16, one cycle read latency.
    initial out_mem_rdata = '0;
    always @(posedge clk) begin
        if (out_mem_read) begin
            out_mem_rdata <= 24'(out_mem_addr + 32'd16);
        end
    end

    // Expected markers {sof,eof,sol,eol} for raster index i of a 4x3 frame.
    function automatic logic [3:0] exp_mark(input int i);
        logic [3:0] m;
        m[3] = (i == 0);
        m[2] = (i == N - 1);
        m[1] = ((i % W) == 0);
        m[0] = ((i % W) == W - 1);
        return m;
    endfunction

    // Drives one frame: start in cycle 0, optional re-pulse, ready pattern per rmode
    // (0: always, 1: one cycle in three, 2: held low through cycle 20). Records
    // accepted pixels and protocol observations; comparisons are left to the callers.
    task automatic run_frame(input int rmode, input int repulse,
                             output int done_cyc, output int rd_by20, output int first_valid);
        logic        stall_prev;
        logic [23:0] d_prev;
        logic [3:0]  m_prev;
        int acc;
        int issued;
        q_data.delete();
        q_mark.delete();
        stab_viol = 0; over_viol = 0; addr_viol = 0; wr_viol = 0;
        done_cyc = -1; rd_by20 = 0; first_valid = -1;
        acc = 0; issued = 0; stall_prev = 1'b0; d_prev = '0; m_prev = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (cyc == repulse);
            case (rmode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ((cyc % 3) == 0);
                default: pix_ready = (cyc > 20);
            endcase
            if (cyc > 0 && done) begin
                done_cyc = cyc;
                break;
            end
            if (out_mem_write) wr_viol++;
            if (en_out_mem) begin
                if (out_mem_addr != 32'(issued)) addr_viol++;
                issued++;
                if (cyc <= 20) rd_by20++;
            end
            if (stall_prev && (!pix_valid || pix_data != d_prev || marks != m_prev)) stab_viol++;
            if (pix_valid && first_valid < 0) first_valid = cyc;
            if (pix_valid && pix_ready) begin
                q_data.push_back(pix_data);
                q_mark.push_back(marks);
                acc++;
            end
            if (issued - acc > 4) over_viol++;
            stall_prev = pix_valid && !pix_ready;
            d_prev = pix_data;
            m_prev = marks;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        outs = {en_out_mem, out_mem_read, out_mem_write, out_mem_addr, pix_valid,
                pix_data, marks, busy, done};
        vecs++;
        if (outs !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got %h, want 0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if ({busy, done, en_out_mem} !== 3'b000) begin
            errs++;
            $display("FAIL idle_after_reset: busy/done/en=%b, want 000", {busy, done, en_out_mem});
        end
    endtask

    task automatic test_frame_basic();
        int dc, r20, fv;
        run_frame(0, -1, dc, r20, fv);
        vecs++;
        if (dc != N + 3) begin
            errs++;
            $display("FAIL basic_done_cycle: got %0d, want %0d", dc, N + 3);
        end
        vecs++;
        if (fv != 3) begin
            errs++;
            $display("FAIL basic_first_valid: got cycle %0d, want 3", fv);
        end
        vecs++;
        if (q_data.size() != N) begin
            errs++;
            $display("FAIL basic_count: got %0d pixels, want %0d", q_data.size(), N);
        end
        for (int i = 0; i < q_data.size() && i < N; i++) begin
            vecs++;
            if (q_data[i] !== 24'(16 + i) || q_mark[i] !== exp_mark(i)) begin
                errs++;
                $display("FAIL basic_pix%0d: data %0d marks %b, want %0d marks %b",
                         i, q_data[i], q_mark[i], 16 + i, exp_mark(i));
            end
        end
        vecs++;
        if (addr_viol != 0 || wr_viol != 0) begin
            errs++;
            $display("FAIL basic_addr_write: addr errors %0d write highs %0d, want 0 0",
                     addr_viol, wr_viol);
        end
        vecs++;
        if ({busy, done} !== 2'b01) begin
            errs++;
            $display("FAIL basic_status: busy/done=%b, want 01", {busy, done});
        end
    endtask

    task automatic test_backpressure();
        int dc, r20, fv;
        run_frame(1, -1, dc, r20, fv);
        vecs++;
        if (dc < 0) begin
            errs++;
            $display("FAIL bp_timeout: done not seen within budget");
        end
        vecs++;
        if (q_data.size() != N) begin
            errs++;
            $display("FAIL bp_count: got %0d pixels, want %0d", q_data.size(), N);
        end
        for (int i = 0; i < q_data.size() && i < N; i++) begin
            vecs++;
            if (q_data[i] !== 24'(16 + i) || q_mark[i] !== exp_mark(i)) begin
                errs++;
                $display("FAIL bp_pix%0d: data %0d marks %b, want %0d marks %b",
                         i, q_data[i], q_mark[i], 16 + i, exp_mark(i));
            end
        end
        vecs++;
        if (stab_viol != 0 || over_viol != 0) begin
            errs++;
            $display("FAIL bp_protocol: stability errors %0d overfill %0d, want 0 0",
                     stab_viol, over_viol);
        end
    endtask

    task automatic test_start_ignored();
        int dc, r20, fv;
        int extra_rd;
        run_frame(0, 5, dc, r20, fv);
        vecs++;
        if (dc != N + 3 || q_data.size() != N) begin
            errs++;
            $display("FAIL repulse_frame: done cycle %0d pixels %0d, want %0d %0d",
                     dc, q_data.size(), N + 3, N);
        end
        extra_rd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (en_out_mem || !done) extra_rd++;
        end
        vecs++;
        if (extra_rd != 0) begin
            errs++;
            $display("FAIL repulse_no_second_frame: %0d bad cycles, want 0", extra_rd);
        end
        // A fresh start from DONE reads the same frame again from address 0.
        run_frame(0, -1, dc, r20, fv);
        vecs++;
        if (dc != N + 3 || q_data.size() != N || addr_viol != 0) begin
            errs++;
            $display("FAIL second_frame: done cycle %0d pixels %0d addr errors %0d, want %0d %0d 0",
                     dc, q_data.size(), addr_viol, N + 3, N);
        end
        for (int i = 0; i < q_data.size() && i < N; i++) begin
            vecs++;
            if (q_data[i] !== 24'(16 + i)) begin
                errs++;
                $display("FAIL second_pix%0d: got %0d, want %0d", i, q_data[i], 16 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dc, r20, fv;
        int hit;
        logic [63:0] outs;
        hit = 0;
        pix_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            if (pix_valid && pix_data == 24'd21) begin
                hit = 1;
                rst = 1'b1;
                break;
            end
        end
        start = 1'b0;
        vecs++;
        if (hit == 0) begin
            errs++;
            $display("FAIL rstmid_reach_pix5: pixel 5 never at head");
        end
        @(negedge clk);
        outs = {en_out_mem, out_mem_read, out_mem_write, out_mem_addr, pix_valid,
                pix_data, marks, busy, done};
        vecs++;
        if (outs !== '0) begin
            errs++;
            $display("FAIL rstmid_outputs: got %h, want 0", outs);
        end
        rst = 1'b0;
        run_frame(0, -1, dc, r20, fv);
        vecs++;
        if (dc != N + 3 || fv != 3 || q_data.size() != N) begin
            errs++;
            $display("FAIL rstmid_refrm: done %0d first %0d pixels %0d, want %0d 3 %0d",
                     dc, fv, q_data.size(), N + 3, N);
        end
        for (int i = 0; i < q_data.size() && i < N; i++) begin
            vecs++;
            if (q_data[i] !== 24'(16 + i) || q_mark[i] !== exp_mark(i)) begin
                errs++;
                $display("FAIL rstmid_pix%0d: data %0d marks %b, want %0d marks %b",
                         i, q_data[i], q_mark[i], 16 + i, exp_mark(i));
            end
        end
    endtask

    task automatic test_stall();
        int dc, r20, fv;
        run_frame(2, -1, dc, r20, fv);
        vecs++;
        if (r20 != 4) begin
            errs++;
            $display("FAIL stall_reads: got %0d reads while stalled, want 4", r20);
        end
        vecs++;
        if (over_viol != 0 || stab_viol != 0) begin
            errs++;
            $display("FAIL stall_protocol: overfill %0d stability %0d, want 0 0",
                     over_viol, stab_viol);
        end
        vecs++;
        if (dc < 0 || q_data.size() != N) begin
            errs++;
            $display("FAIL stall_frame: done %0d pixels %0d, want done and %0d", dc, q_data.size(), N);
        end
        for (int i = 0; i < q_data.size() && i < N; i++) begin
            vecs++;
            if (q_data[i] !== 24'(16 + i)) begin
                errs++;
                $display("FAIL stall_pix%0d: got %0d, want %0d", i, q_data[i], 16 + i);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pix_ready = 1'b0;
        test_reset();
        test_frame_basic();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
